// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg
//   Shared constants for the interrupt controller: source count, register
//   window offsets (word offset = PrAddr[4:2]), the bridge window base and a
//   lowest-index-wins priority encoder used to build the VEC register.
package irq_ctrl_pkg;

    localparam int N_SRC  = 6;
    localparam int LOST_W = 8;

    localparam logic [2:0] IRQ_PEND = 3'd0;
    localparam logic [2:0] IRQ_MASK = 3'd1;
    localparam logic [2:0] IRQ_EDGE = 3'd2;
    localparam logic [2:0] IRQ_VEC  = 3'd3;
    localparam logic [2:0] IRQ_LOST = 3'd4;

    // Window base used by the bridge address decoder.
    localparam logic [31:0] IRQ_BASE = 32'h0000_7F20;

    // Index of the lowest set bit, 0 when nothing is set.
    function automatic logic [2:0] prio_idx(input logic [N_SRC-1:0] v);
        prio_idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) prio_idx = 3'(i);
        end
    endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync
//   One interrupt line: SYNC_STG-flop synchroniser followed by one extra
//   flop holding the previous synchronised value, giving a rising-edge pulse.
// Ports
//   clk   : clock
//   reset : asynchronous, active-low reset
//   din   : raw line, asynchronous to clk
//   s     : synchronised level
//   rise  : one-cycle pulse when s goes 0 -> 1
module irq_sync
    import irq_ctrl_pkg::*;
#(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic s,
    output logic rise
);

    logic [SYNC_STG-1:0] chain;
    logic                prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STG-2:0], din};
            prev  <= chain[SYNC_STG-1];
        end
    end

    assign s    = chain[SYNC_STG-1];
    assign rise = s & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl
//   Interrupt controller feeding CPU HWInt[7:2]. Each source is synchronised,
//   edge-detected, latched into PEND (edge mode) or followed (level mode),
//   masked by MASK and registered onto hwint. LOST counts cycles in which an
//   edge-mode rise hit an already-pending source.
// Ports
//   clk   : clock
//   reset : asynchronous, active-low reset
//   src   : raw interrupt lines, bit i = source i
//   sel   : bridge select
//   addr  : word offset in the window (0 PEND, 1 MASK, 2 EDGE, 3 VEC, 4 LOST)
//   we    : write strobe, only effective together with sel
//   wd    : write data
//   rd    : read data, combinational from registers, no read side effects
//   hwint : registered PEND & MASK
// Bus access: a write takes effect at the clock edge where sel && we is high;
// there is no wait state and no handshake back to the bridge.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int               SYNC_STG = 2,
    parameter logic [N_SRC-1:0] EDGE_RST = 6'b111111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    input  logic             sel,
    input  logic [2:0]       addr,
    input  logic             we,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    output logic [N_SRC-1:0] hwint
);

    logic [N_SRC-1:0]  s, rise;
    logic [N_SRC-1:0]  pend_q, mask_q, edge_q, pend_d, pm;
    logic [LOST_W-1:0] lost_q;
    logic              wr_pend, wr_mask, wr_edge, wr_lost, lost_hit;
    logic              unused_wd_hi;

    for (genvar i = 0; i < N_SRC; i++) begin : g_sync
        irq_sync #(.SYNC_STG(SYNC_STG)) u_sync (
            .clk  (clk),
            .reset(reset),
            .din  (src[i]),
            .s    (s[i]),
            .rise (rise[i])
        );
    end

    assign wr_pend = sel & we & (addr == IRQ_PEND);
    assign wr_mask = sel & we & (addr == IRQ_MASK);
    assign wr_edge = sel & we & (addr == IRQ_EDGE);
    assign wr_lost = sel & we & (addr == IRQ_LOST);

    // Only the low bits are architectural; LOST clears on any written value.
    assign unused_wd_hi = ^wd[31:N_SRC];

    // A source counts as lost when it is in edge mode this cycle, even if
    // the same cycle switches its mode.
    assign lost_hit = |(rise & edge_q & pend_q);

    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (wr_edge && (wd[i] != edge_q[i])) begin
                // Mode change discards whatever was pending for that source.
                pend_d[i] = 1'b0;
            end else if (edge_q[i]) begin
                // New rise beats a simultaneous W1C acknowledge.
                if (rise[i])                 pend_d[i] = 1'b1;
                else if (wr_pend && wd[i])   pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = s[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            mask_q <= '0;
            edge_q <= EDGE_RST;
            lost_q <= '0;
            hwint  <= '0;
        end else begin
            pend_q <= pend_d;
            if (wr_mask) mask_q <= wd[N_SRC-1:0];
            if (wr_edge) edge_q <= wd[N_SRC-1:0];
            if (wr_lost) begin
                lost_q <= '0;
            end else if (lost_hit && (lost_q != '1)) begin
                lost_q <= lost_q + LOST_W'(1);
            end
            hwint <= pend_q & mask_q;
        end
    end

    assign pm = pend_q & mask_q;

    always_comb begin
        rd = '0;
        case (addr)
            IRQ_PEND: rd[N_SRC-1:0]  = pend_q;
            IRQ_MASK: rd[N_SRC-1:0]  = mask_q;
            IRQ_EDGE: rd[N_SRC-1:0]  = edge_q;
            IRQ_VEC: begin
                rd[31]  = |pm;
                rd[2:0] = prio_idx(pm);
            end
            IRQ_LOST: rd[LOST_W-1:0] = lost_q;
            default:  rd = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl
//   Bench for irq_ctrl: register-access vector table, hand-written sequences
//   for latency / ack / level / priority / LOST / async reset, then random
//   traffic checked every cycle against a behavioural model.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  src;
    logic        sel, we;
    logic [2:0]  addr;
    logic [31:0] wd, rd;
    logic [5:0]  hwint;

    always #5 clk = ~clk;

    irq_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .src  (src),
        .sel  (sel),
        .addr (addr),
        .we   (we),
        .wd   (wd),
        .rd   (rd),
        .hwint(hwint)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural model ----------------
    // src is seen as a pure delay line: the synchronised value acting at
    // edge k is src captured at edge k-2, the previous one at k-3.
    logic [5:0] hist[$];
    logic [5:0] exp_q[$];
    logic [5:0] m_pend, m_mask, m_edge;
    int         m_lost;

    task automatic model_reset();
        hist   = {6'h0, 6'h0, 6'h0};
        exp_q  = {};
        m_pend = 6'h0;
        m_mask = 6'h0;
        m_edge = 6'h3F;
        m_lost = 0;
    endtask

    task automatic model_update();
        logic [5:0] sv, pv, rs, np;
        logic       hit, wr;
        sv  = hist[1];
        pv  = hist[2];
        rs  = sv & ~pv;
        wr  = sel && we;
        hit = 1'b0;
        np  = m_pend;
        for (int i = 0; i < 6; i++) begin
            if (m_edge[i] && rs[i] && m_pend[i]) hit = 1'b1;
            if (wr && addr == 3'd2 && wd[i] != m_edge[i]) np[i] = 1'b0;
            else if (m_edge[i]) begin
                if (rs[i]) np[i] = 1'b1;
                else if (wr && addr == 3'd0 && wd[i]) np[i] = 1'b0;
            end else np[i] = sv[i];
        end
        exp_q.push_back(m_pend & m_mask);
        m_pend = np;
        if (wr && addr == 3'd1) m_mask = wd[5:0];
        if (wr && addr == 3'd2) m_edge = wd[5:0];
        if (wr && addr == 3'd4) m_lost = 0;
        else if (hit && m_lost < 255) m_lost++;
        hist.push_front(src);
        void'(hist.pop_back());
    endtask

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        logic [5:0] pm;
        int         idx;
        pm = m_pend & m_mask;
        case (a)
            3'd0: return {26'h0, m_pend};
            3'd1: return {26'h0, m_mask};
            3'd2: return {26'h0, m_edge};
            3'd3: begin
                idx = 0;
                for (int i = 5; i >= 0; i--) if (pm[i]) idx = i;
                return (pm != 0) ? (32'h8000_0000 | 32'(idx)) : 32'h0;
            end
            3'd4: return 32'(m_lost);
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        logic [5:0] e;
        @(posedge clk);
        model_update();
        @(negedge clk);
        e = exp_q.pop_front();
        check("model_hwint", {26'h0, hwint}, {26'h0, e});
        check("model_rd", rd, exp_rd(addr));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wd = d;
        step();
        sel = 1'b0; we = 1'b0; wd = 32'h0;
    endtask

    task automatic rdchk(input logic [2:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        check(name, rd, exp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        sel;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 3'd1, 32'hFFFF_FFEA, 32'h2A};
        tbl[1]  = '{1'b0, 1'b0, 3'd1, 32'h0,         32'h2A};
        tbl[2]  = '{1'b1, 1'b1, 3'd2, 32'h15,        32'h15};
        tbl[3]  = '{1'b1, 1'b0, 3'd2, 32'h0,         32'h15};
        tbl[4]  = '{1'b1, 1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 3'd1, 32'h0,         32'h2A};
        tbl[6]  = '{1'b0, 1'b0, 3'd6, 32'h0,         32'h0};
        tbl[7]  = '{1'b0, 1'b0, 3'd7, 32'h0,         32'h0};
        tbl[8]  = '{1'b0, 1'b1, 3'd1, 32'h3F,        32'h2A};
        tbl[9]  = '{1'b0, 1'b0, 3'd3, 32'h0,         32'h0};
        tbl[10] = '{1'b1, 1'b1, 3'd4, 32'h0,         32'h0};
        tbl[11] = '{1'b1, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'h3F};
        tbl[12] = '{1'b1, 1'b1, 3'd1, 32'h0,         32'h0};

        // ---------------- reset ----------------
        reset = 1'b0; src = 6'h0; sel = 1'b0; we = 1'b0; addr = 3'd0; wd = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("rst_hwint", {26'h0, hwint}, 32'h0);
        rdchk(3'd0, 32'h0,  "rst_pend");
        rdchk(3'd1, 32'h0,  "rst_mask");
        rdchk(3'd2, 32'h3F, "rst_edge");
        rdchk(3'd3, 32'h0,  "rst_vec");
        rdchk(3'd4, 32'h0,  "rst_lost");

        // ---------------- table ----------------
        for (int i = 0; i < 13; i++) begin
            sel = tbl[i].sel; we = tbl[i].we; addr = tbl[i].addr; wd = tbl[i].wd;
            step();
            check($sformatf("tbl_%0d", i), rd, tbl[i].exp_rd);
        end
        sel = 1'b0; we = 1'b0; wd = 32'h0;

        // ---------------- 1: edge latency ----------------
        wr(3'd1, 32'h01);
        src = 6'h01;
        step(); step();
        rdchk(3'd0, 32'h0, "t1_pend_e1");
        step();
        rdchk(3'd0, 32'h1, "t1_pend_e2");
        check("t1_hwint_e2", {26'h0, hwint}, 32'h0);
        src = 6'h00;
        step();
        check("t1_hwint_e3", {26'h0, hwint}, 32'h1);
        rdchk(3'd3, 32'h8000_0000, "t1_vec");

        // ---------------- 2: ack collides with new rise ----------------
        repeat (4) step();
        src = 6'h01;
        step(); step();
        sel = 1'b1; we = 1'b1; addr = 3'd0; wd = 32'h1;
        step();
        sel = 1'b0; we = 1'b0; wd = 32'h0;
        rdchk(3'd0, 32'h1, "t2_pend_set_wins");
        rdchk(3'd4, 32'h1, "t2_lost");
        wr(3'd0, 32'h1);
        rdchk(3'd0, 32'h0, "t2_ack");

        // ---------------- 3: level mode ----------------
        wr(3'd2, 32'h0);
        src = 6'h08;
        wr(3'd1, 32'h08);
        repeat (4) step();
        check("t3_hwint_level", {26'h0, hwint}, 32'h08);
        wr(3'd0, 32'h08);
        rdchk(3'd0, 32'h08, "t3_w1c_ignored");
        src = 6'h00;
        repeat (3) step();
        rdchk(3'd0, 32'h0, "t3_pend_drop");
        check("t3_hwint_hold", {26'h0, hwint}, 32'h08);
        step();
        check("t3_hwint_drop", {26'h0, hwint}, 32'h0);

        // ---------------- 4: priority ----------------
        wr(3'd2, 32'h3F);
        src = 6'h24;
        step();
        src = 6'h00;
        repeat (5) step();
        wr(3'd1, 32'h3F);
        rdchk(3'd3, 32'h8000_0002, "t4_vec_all");
        wr(3'd1, 32'h20);
        rdchk(3'd3, 32'h8000_0005, "t4_vec_masked");
        check("t4_hwint_old", {26'h0, hwint}, 32'h24);
        step();
        check("t4_hwint_new", {26'h0, hwint}, 32'h20);
        wr(3'd0, 32'h3F);
        wr(3'd1, 32'h0);

        // ---------------- 5: LOST saturation ----------------
        for (int i = 0; i < 100; i++) begin
            src = 6'h02; step();
            src = 6'h00; step();
        end
        repeat (4) step();
        rdchk(3'd4, 32'd100, "t5_lost_100");
        for (int i = 0; i < 200; i++) begin
            src = 6'h02; step();
            src = 6'h00; step();
        end
        repeat (4) step();
        rdchk(3'd4, 32'd255, "t5_lost_sat");
        wr(3'd4, 32'h1234_5678);
        rdchk(3'd4, 32'd0, "t5_lost_clr");
        wr(3'd0, 32'h3F);

        // ---------------- 6: async reset ----------------
        src = 6'h3F;
        step();
        src = 6'h00;
        repeat (5) step();
        wr(3'd1, 32'h3F);
        step();
        check("t6_hwint_set", {26'h0, hwint}, 32'h3F);
        #2;
        reset = 1'b0;
        #1;
        check("t6_hwint_async", {26'h0, hwint}, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rdchk(3'd0, 32'h0,  "t6_pend");
        rdchk(3'd2, 32'h3F, "t6_edge");
        rdchk(3'd1, 32'h0,  "t6_mask");
        check("t6_hwint_after", {26'h0, hwint}, 32'h0);

        // ---------------- random traffic ----------------
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 3) == 0) src[b] = ~src[b];
            end
            if ($urandom_range(0, 9) < 2) begin
                sel = 1'b1; we = 1'b1;
                addr = 3'($urandom_range(0, 7));
                wd = $urandom;
            end else begin
                sel = 1'($urandom_range(0, 1));
                we = sel ? 1'b0 : 1'($urandom_range(0, 1));
                addr = 3'($urandom_range(0, 7));
                wd = $urandom;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
